// File: rtl/adc_sar_converter.sv
// Successive-approximation ADC sequencer for the soc/eoc handshake.
// The block drives a trial code to an external DAC and resolves one bit per
// SETTLE cycles from the comparator. It resolves the MSB first.
module adc_sar_converter #(
    parameter int unsigned N      = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soc,
    output logic         eoc,
    output logic [N-1:0] x,
    output logic [N-1:0] dac,
    input  logic         cmp
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] Lsb = N'(1);
    localparam logic [N-1:0] Msb = Lsb << (N - 1);

    typedef enum logic [1:0] {StIdle, StAck, StConv} state_e;

    state_e         state_q, state_d;
    logic           eoc_q, eoc_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   dac_q, dac_d;
    logic [KW-1:0]  k_q, k_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   resolved;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            eoc_q   <= 1'b1;
            x_q     <= '0;
            dac_q   <= '0;
            k_q     <= KW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
            x_q     <= x_d;
            dac_q   <= dac_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Resolve the bit under test. The trial bit is already set, so a low cmp clears it.
    always_comb begin
        resolved      = dac_q;
        resolved[k_q] = dac_q[k_q] & cmp;
    end

    // Handshake and conversion sequencing.
    always_comb begin
        state_d = state_q;
        eoc_d   = eoc_q;
        x_d     = x_q;
        dac_d   = dac_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (soc) begin
                    eoc_d   = 1'b0;
                    state_d = StAck;
                end
            end
            StAck: begin
                // The conversion starts only after the consumer releases soc.
                if (!soc) begin
                    dac_d   = Msb;
                    cnt_d   = CW'(SETTLE);
                    k_d     = KW'(N - 1);
                    state_d = StConv;
                end
            end
            StConv: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (k_q != '0) begin
                    dac_d = resolved | (Lsb << (k_q - KW'(1)));
                    k_d   = k_q - KW'(1);
                    cnt_d = CW'(SETTLE);
                end else begin
                    x_d     = resolved;
                    dac_d   = resolved;
                    eoc_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign eoc = eoc_q;
    assign x   = x_q;
    assign dac = dac_q;

endmodule

// File: tb/tb_adc_sar_converter.sv
// Scoreboard bench for adc_sar_converter using an ideal vin >= dac comparator.
module tb_adc_sar_converter;

    localparam int N = 8;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         soc   = 1'b1;
    logic         eoc;
    logic [N-1:0] x;
    logic [N-1:0] dac;
    logic         cmp;
    logic [N-1:0] vin = 8'hFF;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] v;
        int           rel;
    } exp_t;
    exp_t sb[$];

    adc_sar_converter #(.N(N), .SETTLE(S)) u_dut (
        .clock (clock),
        .reset (reset),
        .soc   (soc),
        .eoc   (eoc),
        .x     (x),
        .dac   (dac),
        .cmp   (cmp)
    );

    assign cmp = (vin >= dac);

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Binary search on an ideal comparator: the trial code shown for bit index i.
    function automatic logic [N-1:0] trial_code(input logic [N-1:0] v, input int i);
        logic [N-1:0] code = '0;
        logic [N-1:0] t;
        for (int j = 0; j < i; j++) begin
            t = code | (N'(1) << (N - 1 - j));
            if (v >= t) code = t;
        end
        return code | (N'(1) << (N - 1 - i));
    endfunction

    // Monitor: check the trial sequence, the result, the latency and that x is held.
    logic         prev_eoc = 1'b1;
    logic [N-1:0] prev_x   = '0;
    always @(negedge clock) begin
        if (reset) begin
            prev_eoc = eoc;
            prev_x   = x;
        end else begin
            if (!prev_eoc && eoc) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_eoc", x, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(x === e.v, "result_x", x, e.v);
                    chk(dac === e.v, "final_dac", dac, e.v);
                    chk(cyc - e.rel == N * S + 1, "latency", cyc - e.rel - 1, N * S);
                end
            end else begin
                chk(x === prev_x, "x_hold", x, prev_x);
                if (sb.size() != 0) begin
                    int d;
                    d = cyc - sb[0].rel - 1;
                    if (d >= 0 && d < N * S) begin
                        logic [N-1:0] t;
                        t = trial_code(sb[0].v, d / S);
                        chk(dac === t, "dac_trial", dac, t);
                    end
                end
            end
            prev_eoc = eoc;
            prev_x   = x;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_eoc(input logic val, input int budget);
        int n = 0;
        while (eoc !== val && n < budget) begin
            tick();
            n++;
        end
        chk(eoc === val, "eoc_wait", eoc, val);
    endtask

    // From ACK: hold soc for 'hold' cycles, release it and optionally toggle soc during CONV.
    task automatic run_from_ack(input logic [N-1:0] v, input int hold, input bit toggle);
        logic [N-1:0] d0;
        d0 = dac;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk(eoc === 1'b0, "ack_eoc", eoc, 0);
            chk(dac === d0, "ack_dac", dac, d0);
        end
        soc = 1'b0;
        sb.push_back('{v: v, rel: cyc});
        if (toggle) begin
            for (int i = 0; i < N * S - 2; i++) begin
                tick();
                soc = 1'($urandom);
            end
            tick();
            soc = 1'b0;
        end
        wait_eoc(1'b1, N * S + 8);
    endtask

    task automatic convert(input logic [N-1:0] v, input int hold, input bit toggle);
        wait_eoc(1'b1, 40);
        vin = v;
        soc = 1'b1;
        tick();
        chk(eoc === 1'b0, "soc_ack", eoc, 0);
        soc = hold > 0;
        run_from_ack(v, hold, toggle);
    endtask

    initial begin
        // Reset with soc=1 and cmp=1.
        #12;
        chk(eoc === 1'b1, "reset_eoc", eoc, 1);
        chk(x === 8'h00, "reset_x", x, 0);
        chk(dac === 8'h00, "reset_dac", dac, 0);
        tick();
        reset = 1'b0;
        chk(eoc === 1'b1, "idle_after_reset", eoc, 1);
        tick();
        chk(eoc === 1'b0, "ack_after_reset", eoc, 0);
        run_from_ack(8'hFF, 1, 1'b0);

        // Directed values: MSB pattern, all zero, long ACK hold with a CONV toggle.
        convert(8'hA5, 0, 1'b0);
        convert(8'h00, 0, 1'b0);
        convert(8'hFF, 0, 1'b0);
        convert(8'h5A, 5, 1'b1);

        // Reset while bit 3 is on trial.
        wait_eoc(1'b1, 40);
        vin = 8'h3C;
        soc = 1'b1;
        tick();
        soc = 1'b0;
        sb.push_back('{v: 8'h3C, rel: cyc});
        repeat (4 * S + 1) tick();
        chk(dac === trial_code(8'h3C, 4), "pre_abort_dac", dac, trial_code(8'h3C, 4));
        reset = 1'b1;
        #1;
        chk(eoc === 1'b1, "abort_eoc", eoc, 1);
        chk(x === 8'h00, "abort_x", x, 0);
        chk(dac === 8'h00, "abort_dac", dac, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        convert(8'h3C, 0, 1'b0);

        // Back-to-back handshakes.
        convert(8'h12, 0, 1'b0);
        convert(8'hE7, 1, 1'b0);

        // Random values, hold lengths and soc noise during CONV.
        for (int i = 0; i < 12; i++) begin
            convert(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
